// File: rtl/ztex_host_link_if.sv
// ztex_host_link_if
//   Byte-wide toggle-strobed link between the host-side initiator and a miner.
//   master : host side (drives read/rd_clk/wr_start/wr_clk, receives write)
//   slave  : miner side
// Signals:
//   rd_clk   host->miner  work strobe, every level change carries one byte
//   read     host->miner  work byte
//   wr_start host->miner  result latch request
//   wr_clk   host->miner  result strobe, every level change advances one byte
//   write    miner->host  result byte (asynchronous to the host clock)
interface ztex_host_link_if;
    logic       rd_clk;
    logic [7:0] read;
    logic       wr_start;
    logic       wr_clk;
    logic [7:0] write;

    modport master (
        output rd_clk,
        output read,
        output wr_start,
        output wr_clk,
        input  write
    );

    modport slave (
        input  rd_clk,
        input  read,
        input  wr_start,
        input  wr_clk,
        output write
    );
endinterface

// File: rtl/ztex_host_link.sv
// ztex_host_link
//   Host-side initiator for the 8-bit toggle-strobed miner link. Serialises a
//   352-bit work word (LSB byte first, 44 bytes) and retrieves the 96-bit
//   result {hash2, nonce2, golden_nonce} on request or on a poll timer.
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   work_valid/work_ready/work_data   work word handshake ([351:96] midstate)
//   poll_req       one-cycle request for an immediate result poll
//   result_valid   one-cycle pulse, result_data holds the new result
//   result_data    {hash2, nonce2, golden_nonce}
//   busy           FSM not idle
//   link           ztex_host_link_if.master toward the miner
// Optional feature (macro ZTEX_HOST_LINK_NONCE_FILTER_EN):
//   result_valid pulses only when golden_nonce differs from the previous one.
module ztex_host_link #(
    parameter int HALF_PERIOD   = 8,
    parameter int START_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 12,
    parameter int POLL_INTERVAL = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             work_valid,
    output logic             work_ready,
    input  logic [351:0]     work_data,
    input  logic             poll_req,
    output logic             result_valid,
    output logic [95:0]      result_data,
    output logic             busy,
    ztex_host_link_if.master link
);

    localparam int TMAX_A = (HALF_PERIOD > START_CYCLES) ? HALF_PERIOD : START_CYCLES;
    localparam int TMAX   = (TMAX_A > SETTLE_CYCLES) ? TMAX_A : SETTLE_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HALF_LAST   = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] START_LAST  = TW'(START_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

    localparam int PLAST = (POLL_INTERVAL > 0) ? POLL_INTERVAL - 1 : 0;
    localparam int PW    = (PLAST > 0) ? $clog2(PLAST + 1) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(PLAST);
    localparam bit AUTO_POLL = (POLL_INTERVAL > 0);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_HOLD,
        R_START,
        R_SETTLE,
        R_SAMPLE,
        R_HOLD
    } state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [5:0]     byte_cnt;
    logic [351:0]   shift;
    logic [95:0]    collect;
    logic [PW-1:0]  poll_cnt;
    logic           poll_pend;
    logic           rd_clk_q;
    logic [7:0]     read_q;
    logic           wr_start_q;
    logic           wr_clk_q;
    logic [7:0]     write_meta;
    logic [7:0]     write_sync;
    logic           poll_due;
    logic [95:0]    collect_next;
`ifdef ZTEX_HOST_LINK_NONCE_FILTER_EN
    logic [31:0]    last_golden;
`endif

    assign link.rd_clk   = rd_clk_q;
    assign link.read     = read_q;
    assign link.wr_start = wr_start_q;
    assign link.wr_clk   = wr_clk_q;

    // Reset overrides the state decode so the handshake is closed while
    // reset is held, even when the FSM already sits in IDLE.
    assign work_ready = (state == IDLE) && !reset;
    assign busy       = (state != IDLE);

    assign poll_due     = AUTO_POLL && (poll_cnt == POLL_LAST);
    // Miner sends golden_nonce[7:0] first; inserting at the top and shifting
    // right leaves the first byte at [7:0] after twelve samples.
    assign collect_next = {write_sync, collect[95:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            write_meta <= '0;
            write_sync <= '0;
        end else begin
            write_meta <= link.write;
            write_sync <= write_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            collect      <= '0;
            poll_cnt     <= '0;
            poll_pend    <= 1'b0;
            rd_clk_q     <= 1'b0;
            read_q       <= '0;
            wr_start_q   <= 1'b0;
            wr_clk_q     <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
`ifdef ZTEX_HOST_LINK_NONCE_FILTER_EN
            last_golden  <= '0;
`endif
        end else begin
            result_valid <= 1'b0;

            // Requests seen while busy are kept until the next IDLE visit.
            if (poll_req) begin
                poll_pend <= 1'b1;
            end

            // Poll timer only runs while idle and holds at its terminal count
            // until a poll completes, so a poll that loses to work still fires
            // right after the frame.
            if (state == IDLE && poll_cnt != POLL_LAST) begin
                poll_cnt <= poll_cnt + PW'(1);
            end

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (work_valid) begin
                        shift    <= work_data;
                        read_q   <= work_data[7:0];
                        byte_cnt <= '0;
                        state    <= W_SETUP;
                    end else if (poll_pend || poll_req || poll_due) begin
                        poll_pend  <= 1'b0;
                        wr_start_q <= 1'b1;
                        byte_cnt   <= '0;
                        state      <= R_START;
                    end
                end

                W_SETUP: begin
                    if (timer == HALF_LAST) begin
                        timer    <= '0;
                        rd_clk_q <= ~rd_clk_q;
                        state    <= W_HOLD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                W_HOLD: begin
                    if (timer == HALF_LAST) begin
                        timer  <= '0;
                        shift  <= {8'h00, shift[351:8]};
                        read_q <= shift[15:8];
                        if (byte_cnt == 6'd43) begin
                            state <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                            state    <= W_SETUP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                R_START: begin
                    if (timer == START_LAST) begin
                        timer      <= '0;
                        wr_start_q <= 1'b0;
                        state      <= R_SETTLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                R_SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer <= '0;
                        state <= R_SAMPLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                R_SAMPLE: begin
                    collect <= collect_next;
                    if (byte_cnt == 6'd11) begin
                        result_data <= collect_next;
                        poll_cnt    <= '0;
                        state       <= IDLE;
`ifdef ZTEX_HOST_LINK_NONCE_FILTER_EN
                        result_valid <= (collect_next[31:0] != last_golden);
                        last_golden  <= collect_next[31:0];
`else
                        result_valid <= 1'b1;
`endif
                    end else begin
                        wr_clk_q <= ~wr_clk_q;
                        state    <= R_HOLD;
                    end
                end

                R_HOLD: begin
                    if (timer == HALF_LAST) begin
                        timer    <= '0;
                        byte_cnt <= byte_cnt + 6'd1;
                        state    <= R_SAMPLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ztex_host_link.sv
// tb_ztex_host_link
//   Directed bench for ztex_host_link with a behavioural miner on the link.
//   dut  : polling timer disabled, used for work/poll/priority/reset/filter.
//   dut2 : POLL_INTERVAL=64, idle bus, used for the automatic poll spacing.
module tb_ztex_host_link;

    logic         clk = 1'b0;
    logic         reset;
    logic         work_valid;
    logic         work_ready;
    logic [351:0] work_data;
    logic         poll_req;
    logic         result_valid;
    logic [95:0]  result_data;
    logic         busy;

    logic         work_ready2;
    logic         result_valid2;
    logic [95:0]  result_data2;
    logic         busy2;

    ztex_host_link_if link ();
    ztex_host_link_if link2 ();

    always #5 clk = ~clk;

    ztex_host_link #(
        .HALF_PERIOD  (8),
        .START_CYCLES (4),
        .SETTLE_CYCLES(12),
        .POLL_INTERVAL(0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .work_valid  (work_valid),
        .work_ready  (work_ready),
        .work_data   (work_data),
        .poll_req    (poll_req),
        .result_valid(result_valid),
        .result_data (result_data),
        .busy        (busy),
        .link        (link)
    );

    ztex_host_link #(
        .HALF_PERIOD  (8),
        .START_CYCLES (4),
        .SETTLE_CYCLES(12),
        .POLL_INTERVAL(64)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .work_valid  (1'b0),
        .work_ready  (work_ready2),
        .work_data   ('0),
        .poll_req    (1'b0),
        .result_valid(result_valid2),
        .result_data (result_data2),
        .busy        (busy2),
        .link        (link2)
    );

    assign link2.write = 8'h5A;

    // Miner model: pure 352-bit input shift register plus a 96-bit output
    // register that is latched on wr_start and advanced on each wr_clk edge.
    logic [351:0] inbuf = '0;
    logic [95:0]  outbuf = '0;
    logic [95:0]  miner_word = '0;
    logic         rd_prev = 1'b0;
    logic         wr_prev = 1'b0;
    logic [7:0]   rd_bytes [0:1023];
    int           rd_tog = 0;
    int           wc_tog = 0;
    int           ws_cnt = 0;
    int           rv_cnt = 0;

    assign link.write = outbuf[7:0];

    always @(posedge clk) begin
        rd_prev <= link.rd_clk;
        wr_prev <= link.wr_clk;
        if (link.rd_clk != rd_prev) begin
            inbuf <= {link.read, inbuf[351:8]};
            if (rd_tog < 1024) rd_bytes[rd_tog] <= link.read;
            rd_tog <= rd_tog + 1;
        end
        if (link.wr_start) begin
            outbuf <= miner_word;
            ws_cnt <= ws_cnt + 1;
        end else if (link.wr_clk != wr_prev) begin
            outbuf <= {8'h00, outbuf[95:8]};
        end
        if (link.wr_clk != wr_prev) wc_tog <= wc_tog + 1;
        if (result_valid) rv_cnt <= rv_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [351:0] got, input logic [351:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [351:0] make_frame(input logic [7:0] seed, input logic [7:0] step);
        logic [351:0] f;
        f = '0;
        for (int k = 0; k < 44; k++) begin
            f[8*k +: 8] = seed + step * 8'(k);
        end
        return f;
    endfunction

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        while (busy && c < limit) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic do_poll(input logic [95:0] word);
        miner_word = word;
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        wait_idle(500);
        check("poll_data", result_data, word);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [351:0] frame1, frame2, frame3, frame4;
        int cyc, base, b_wc, b_ws, b_rv, exp_rv, k;

        reset      = 1'b1;
        work_valid = 1'b0;
        work_data  = '0;
        poll_req   = 1'b0;
        frame1 = make_frame(8'h01, 8'h01);
        frame2 = make_frame(8'h35, 8'h07);
        frame3 = make_frame(8'hF0, 8'h03);
        frame4 = make_frame(8'h9C, 8'h0B);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_work_ready", work_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_result_data", result_data, '0);
        check("rst_rd_clk", link.rd_clk, 1'b0);
        check("rst_read", link.read, 8'h00);
        check("rst_wr_start", link.wr_start, 1'b0);
        check("rst_wr_clk", link.wr_clk, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", work_ready, 1'b1);

        // Work frame: byte k = k+1, LSB byte first
        base = rd_tog;
        @(negedge clk);
        work_valid = 1'b1;
        work_data  = frame1;
        @(negedge clk);
        work_valid = 1'b0;
        cyc = 1;
        while (!work_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("work_latency", cyc, 705);
        @(negedge clk);
        check("rd_toggles", rd_tog - base, 44);
        for (int n = 0; n < 44; n++) begin
            check($sformatf("byte%0d", n), rd_bytes[base + n], n + 1);
        end
        check("inbuf_frame1", inbuf, frame1);

        // Result poll
        b_wc = wc_tog;
        b_ws = ws_cnt;
        b_rv = rv_cnt;
        miner_word = 96'hDEADBEEF_00000123_12345678;
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        cyc = 1;
        while (!result_valid && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("poll_latency", cyc, 117);
        check("poll_result", result_data, 96'hDEADBEEF_00000123_12345678);
        repeat (3) @(negedge clk);
        check("poll_rv_pulses", rv_cnt - b_rv, 1);
        check("poll_wr_clk_toggles", wc_tog - b_wc, 11);
        check("poll_wr_start_cycles", ws_cnt - b_ws, 4);

        // Work and poll requested together: full frame, then poll
        base = rd_tog;
        b_rv = rv_cnt;
        b_wc = wc_tog;
        miner_word = 96'h0BADF00D_00000042_87654321;
        @(negedge clk);
        work_valid = 1'b1;
        work_data  = frame2;
        poll_req   = 1'b1;
        @(negedge clk);
        work_valid = 1'b0;
        poll_req   = 1'b0;
        cyc = 1;
        while (!result_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("prio_latency", cyc, 822);
        check("prio_result", result_data, 96'h0BADF00D_00000042_87654321);
        repeat (3) @(negedge clk);
        check("prio_rd_toggles", rd_tog - base, 44);
        check("prio_inbuf", inbuf, frame2);
        check("prio_first_byte", rd_bytes[base], 8'h35);
        check("prio_rv_pulses", rv_cnt - b_rv, 1);
        check("prio_wr_clk_toggles", wc_tog - b_wc, 11);

        // Reset in the middle of a frame
        base = rd_tog;
        @(negedge clk);
        work_valid = 1'b1;
        work_data  = frame3;
        @(negedge clk);
        work_valid = 1'b0;
        k = 0;
        while ((rd_tog - base) < 20 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("midframe_reached", rd_tog - base, 20);
        b_rv = rv_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_work_ready", work_ready, 1'b0);
        check("abort_rd_clk", link.rd_clk, 1'b0);
        check("abort_read", link.read, 8'h00);
        check("abort_wr_start", link.wr_start, 1'b0);
        check("abort_wr_clk", link.wr_clk, 1'b0);
        check("abort_result_valid", result_valid, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_again", work_ready, 1'b1);
        @(negedge clk);
        work_valid = 1'b1;
        work_data  = frame4;
        @(negedge clk);
        work_valid = 1'b0;
        wait_idle(2000);
        repeat (2) @(negedge clk);
        check("abort_inbuf", inbuf, frame4);
        check("abort_no_pulse", rv_cnt - b_rv, 0);

        // Golden-nonce filter: unchanged, unchanged, changed
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        b_rv = rv_cnt;
        do_poll(96'h11111111_00000001_00000000);
        do_poll(96'h22222222_00000002_00000000);
        do_poll(96'h33333333_00000003_CAFEBABE);
`ifdef ZTEX_HOST_LINK_NONCE_FILTER_EN
        exp_rv = 1;
`else
        exp_rv = 3;
`endif
        check("filter_pulses", rv_cnt - b_rv, exp_rv);

        // Automatic polling on the second instance
        for (int r = 0; r < 2; r++) begin
            k = 0;
            while (!busy2 && k < 400) begin
                @(negedge clk);
                k++;
            end
            k = 0;
            while (busy2 && k < 400) begin
                @(negedge clk);
                k++;
            end
            check("auto_idle_reached", busy2, 1'b0);
            k = 0;
            while (!link2.wr_start && k < 200) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("auto_poll_gap%0d", r), k, 64);
        end
        check("auto_result", result_data2, {12{8'h5A}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
